// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem requests, 2-entry instruction queue
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_pc_plus4
);

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] PC_ALIGN  = ~DATA_WIDTH'(3);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  stale_q, stale_d;
  logic                  run_q, run_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] q_instr_q [2];
  logic [DATA_WIDTH-1:0] q_instr_d [2];
  logic [DATA_WIDTH-1:0] q_pc_q    [2];
  logic [DATA_WIDTH-1:0] q_pc_d    [2];

  logic req_fire;
  logic rsp_take;
  logic push;
  logic pop;

  // Outputs and handshake events; run_q holds off the first request for one cycle after reset
  always_comb begin
    imem_req_valid = run_q && (state_q == S_REQ) && (count_q < 2'd2);
    imem_addr      = pc_q;
    if_valid       = (count_q != 2'd0);
    if_instr       = if_valid ? q_instr_q[rd_ptr_q] : NOP_INSTR;
    if_pc          = if_valid ? q_pc_q[rd_ptr_q] : '0;
    if_pc_plus4    = if_pc + PC_STEP;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = (state_q == S_WAIT) && imem_rsp_valid;
    push           = rsp_take && !stale_q && !redirect_valid;
    pop            = if_valid && if_ready && !redirect_valid;
  end

  // Next state: fetch FSM, PC, stale tracking and queue; redirect overrides everything else
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    stale_d   = stale_q;
    run_d     = 1'b1;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;

    if (req_fire) begin
      state_d  = S_WAIT;
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_STEP;
    end
    if (rsp_take) begin
      state_d = S_REQ;
      stale_d = 1'b0;
    end
    if (push) begin
      q_instr_d[wr_ptr_q] = imem_rsp_data;
      q_pc_d[wr_ptr_q]    = req_pc_q;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = redirect_pc & PC_ALIGN;
      // A request still in flight (or launched right now) must have its response dropped
      if (req_fire || ((state_q == S_WAIT) && !imem_rsp_valid)) begin
        stale_d = 1'b1;
        state_d = S_WAIT;
      end else begin
        stale_d = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      stale_q  <= 1'b0;
      run_q    <= 1'b0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      stale_q  <= stale_d;
      run_q    <= run_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage; contents are only observed while count_q says they are valid
  always_ff @(posedge clk) begin
    q_instr_q <= q_instr_d;
    q_pc_q    <= q_pc_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized model-checked bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redir;
  logic [31:0] rpc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_p4;

  logic        hi_req_valid, hi_req_ready, hi_rsp_valid, hi_redir, hi_if_valid, hi_if_ready;
  logic [31:0] hi_addr, hi_rsp_data, hi_rpc, hi_if_instr, hi_if_pc, hi_if_p4;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(rpc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_p4)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(rst),
    .imem_req_valid(hi_req_valid), .imem_req_ready(hi_req_ready), .imem_addr(hi_addr),
    .imem_rsp_valid(hi_rsp_valid), .imem_rsp_data(hi_rsp_data),
    .redirect_valid(hi_redir), .redirect_pc(hi_rpc),
    .if_valid(hi_if_valid), .if_ready(hi_if_ready), .if_instr(hi_if_instr),
    .if_pc(hi_if_pc), .if_pc_plus4(hi_if_p4)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_pend;
  bit          m_busy, m_stale, m_hold, model_on;

  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem_addr;
  int          lat_lo, lat_hi;
  bit          hi_busy;
  logic [31:0] hi_mem_addr;

  logic        s_req_valid, s_if_valid, s_hi_req_valid, s_hi_if_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_p4, s_hi_addr, s_hi_pc, s_hi_p4;
  int          hi_n;
  bit          hi_seen;
  logic [31:0] hi_a0, hi_a1, hi_fpc, hi_fp4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit model_req_valid();
    return !m_hold && !m_busy && (mq.size() < 2);
  endfunction

  task automatic compare_model(input bit mv);
    if (!model_on) return;
    chk("req_valid", {31'b0, s_req_valid}, {31'b0, mv});
    if (mv) chk("imem_addr", s_addr, m_pc);
    chk("if_valid", {31'b0, s_if_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("if_instr", s_instr, mq[0].instr);
      chk("if_pc", s_pc, mq[0].pc);
      chk("if_pc_plus4", s_p4, mq[0].pc + 32'd4);
    end
  endtask

  task automatic model_update(input bit mv);
    bit acc, arr, pp;
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_busy = 0; m_stale = 0; m_hold = 1; model_on = 1;
    end else if (model_on) begin
      acc = mv && req_ready;
      arr = m_busy && rsp_valid;
      pp  = (mq.size() != 0) && if_ready;
      if (redir) begin
        mq.delete();
        m_pc    = rpc & ~32'd3;
        m_stale = acc || (m_busy && !arr);
        m_busy  = m_stale;
      end else begin
        if (pp) void'(mq.pop_front());
        if (arr) begin
          m_busy = 0;
          if (m_stale) m_stale = 0;
          else mq.push_back('{mem_word(m_pend), m_pend});
        end
        if (acc) begin
          m_busy = 1; m_pend = m_pc; m_pc = m_pc + 32'd4;
        end
      end
      m_hold = 0;
    end
  endtask

  task automatic tick();
    bit mv;
    rsp_valid    = mem_busy && (mem_left == 0);
    rsp_data     = rsp_valid ? mem_word(mem_addr) : $urandom;
    hi_rsp_valid = hi_busy;
    hi_rsp_data  = hi_mem_addr;
    @(negedge clk);
    s_req_valid = req_valid; s_addr = addr; s_if_valid = if_valid;
    s_instr = if_instr; s_pc = if_pc; s_p4 = if_p4;
    s_hi_req_valid = hi_req_valid; s_hi_addr = hi_addr; s_hi_if_valid = hi_if_valid;
    s_hi_pc = hi_if_pc; s_hi_p4 = hi_if_p4;
    mv = model_req_valid();
    compare_model(mv);
    if (rst) begin
      hi_n = 0; hi_seen = 0;
    end else begin
      if (s_hi_req_valid && hi_n < 2) begin
        if (hi_n == 0) hi_a0 = s_hi_addr; else hi_a1 = s_hi_addr;
        hi_n++;
      end
      if (s_hi_if_valid && !hi_seen) begin
        hi_seen = 1; hi_fpc = s_hi_pc; hi_fp4 = s_hi_p4;
      end
    end
    @(posedge clk);
    model_update(mv);
    if (rst) begin
      mem_busy = 0; hi_busy = 0;
    end else begin
      if (rsp_valid) mem_busy = 0;
      else if (mem_busy) mem_left--;
      if (s_req_valid && req_ready) begin
        mem_busy = 1;
        mem_left = int'($urandom_range(lat_hi, lat_lo)) - 1;
        mem_addr = s_addr;
      end
      hi_busy = s_hi_req_valid;
      if (s_hi_req_valid) hi_mem_addr = s_hi_addr;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; redir = 0;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    bit          found, seen8, ga, gp;
    logic [31:0] fa, fp;
    rst = 1; req_ready = 1; rsp_valid = 0; rsp_data = 0; redir = 0; rpc = 0; if_ready = 1;
    hi_req_ready = 1; hi_rsp_valid = 0; hi_rsp_data = 0; hi_redir = 0; hi_rpc = 0; hi_if_ready = 1;
    mem_busy = 0; mem_left = 0; mem_addr = 0; hi_busy = 0; hi_mem_addr = 0;
    model_on = 0; hi_n = 0; hi_seen = 0; hi_a0 = 0; hi_a1 = 0; hi_fpc = 0; hi_fp4 = 0;
    lat_lo = 1; lat_hi = 1;

    // reset state and first fetch with a 1-cycle memory
    do_reset();
    tick();
    chk("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, s_if_valid}, 32'd0);
    chk("rst_if_instr", s_instr, 32'h0000_0013);
    chk("rst_if_pc", s_pc, 32'h0);
    tick();
    chk("c1_req_valid", {31'b0, s_req_valid}, 32'd1);
    chk("c1_addr", s_addr, 32'h0);
    tick();
    tick();
    chk("c3_if_valid", {31'b0, s_if_valid}, 32'd1);
    chk("c3_if_instr", s_instr, 32'h0050_0093);
    chk("c3_if_pc", s_pc, 32'h0);
    chk("c3_if_pc_plus4", s_p4, 32'h4);
    chk("c3_next_addr", s_addr, 32'h4);
    tick(); tick();
    chk("hi_first_pc", hi_fpc, 32'hFFFF_FFFC);
    chk("hi_first_pc_plus4", hi_fp4, 32'h0);
    chk("hi_first_addr", hi_a0, 32'hFFFF_FFFC);
    chk("hi_second_addr", hi_a1, 32'h0);

    // backpressure: only two fetches, then in-order drain and resume at 8
    do_reset();
    if_ready = 0;
    fa = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_req_valid && req_ready) fa++;
    end
    chk("bp_fetch_count", fa, 32'd2);
    chk("bp_req_idle", {31'b0, s_req_valid}, 32'd0);
    if_ready = 1;
    tick();
    chk("bp_pop0_pc", s_pc, 32'h0);
    tick();
    chk("bp_pop1_pc", s_pc, 32'h4);
    chk("bp_resume_valid", {31'b0, s_req_valid}, 32'd1);
    chk("bp_resume_addr", s_addr, 32'h8);

    // redirect with the fetch of 0x8 outstanding
    do_reset();
    lat_lo = 3; lat_hi = 3; if_ready = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (s_req_valid && req_ready && s_addr == 32'h8) found = 1;
    end
    chk("rd_saw_req8", {31'b0, found}, 32'd1);
    redir = 1; rpc = 32'h100;
    tick();
    redir = 0;
    seen8 = 0; ga = 0; gp = 0; fa = 0; fp = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_if_valid && s_pc == 32'h8) seen8 = 1;
      if (!ga && s_req_valid) begin ga = 1; fa = s_addr; end
      if (!gp && s_if_valid) begin gp = 1; fp = s_pc; end
    end
    chk("rd_stale_hidden", {31'b0, seen8}, 32'd0);
    chk("rd_next_addr", fa, 32'h100);
    chk("rd_first_if_pc", fp, 32'h100);

    // redirect coinciding with a response and a pop while one entry is queued
    do_reset();
    lat_lo = 2; lat_hi = 2; if_ready = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_busy && mem_left == 0 && mq.size() == 1) begin
        redir = 1; rpc = 32'h200; if_ready = 1;
        tick();
        redir = 0; found = 1;
      end else begin
        tick();
      end
    end
    chk("rc_hit", {31'b0, found}, 32'd1);
    tick();
    chk("rc_if_valid", {31'b0, s_if_valid}, 32'd0);
    chk("rc_req_valid", {31'b0, s_req_valid}, 32'd1);
    chk("rc_addr", s_addr, 32'h200);

    // unaligned redirect target
    redir = 1; rpc = 32'h103;
    tick();
    redir = 0;
    ga = 0; fa = 0;
    for (int i = 0; i < 20 && !ga; i++) begin
      tick();
      if (s_req_valid) begin ga = 1; fa = s_addr; end
    end
    chk("ua_addr", fa, 32'h100);

    // reset while waiting with one queued entry
    do_reset();
    lat_lo = 3; lat_hi = 3; if_ready = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mq.size() == 1 && m_busy) found = 1;
    end
    chk("mr_hit", {31'b0, found}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("mr_if_valid", {31'b0, s_if_valid}, 32'd0);
    chk("mr_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("mr_if_instr", s_instr, 32'h0000_0013);
    tick();
    chk("mr_restart_addr", s_addr, 32'h0);

    // randomized traffic against the model
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      req_ready = ($urandom_range(9, 0) < 7);
      if_ready  = ($urandom_range(9, 0) < 6);
      redir     = ($urandom_range(19, 0) == 0);
      rpc       = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      rst       = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 0; redir = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and issues word requests to instruction memory.
- Buffers returned instructions in a 2-entry queue and presents {instr, pc, pc+4} to decode over a valid/ready handshake.
- Accepts a redirect from the branch/jump resolution logic, flushes queued instructions and discards any stale in-flight response.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and memory data; only 32 is supported.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_ready, input, 1, memory accepts the request this cycle.
- imem_addr, output, DATA_WIDTH, word-aligned fetch address.
- imem_rsp_valid, input, 1, response data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data, input, DATA_WIDTH, fetched instruction word.
- redirect_valid, input, 1, taken branch, jal or jalr; next fetch comes from redirect_pc.
- redirect_pc, input, DATA_WIDTH, target PC; bits [1:0] are forced to 0 internally.
- if_valid, output, 1, queue head is valid for decode.
- if_ready, input, 1, decode consumes the head this cycle.
- if_instr, output, DATA_WIDTH, head instruction.
- if_pc, output, DATA_WIDTH, head instruction address.
- if_pc_plus4, output, DATA_WIDTH, if_pc + 4, modulo 2^32; feeds the PC+4 writeback path.

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in this state:
  - pc_q=RESET_PC, state=REQ, queue empty, outstanding=0, stale=0.
  - Outputs: imem_req_valid=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0.
  - Reset mid-transaction drops any in-flight response silently. Memory is reset on the same rst, so no response from before the reset arrives afterwards.
- Credit rule: a request may issue only when (queue occupancy + outstanding) < 2. The queue therefore never overflows.
- FSM:
  - REQ: imem_req_valid=credit_ok, imem_addr=pc_q. On valid&&ready: outstanding<=1, pc_q<=pc_q+4 (wraps 0xFFFF_FFFC to 0), state<=WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid: outstanding<=0, state<=REQ. If stale=1, the response is discarded and stale<=0. Otherwise {imem_rsp_data, PC of the request} is pushed to the queue tail.
- At most one request is outstanding, so peak throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Queue:
  - 2-entry FIFO; if_valid = !empty; outputs reflect the head combinationally from registers.
  - Pop on if_valid&&if_ready.
  - Push and pop in the same cycle is legal, and occupancy is unchanged.
  - A response pushed at edge N is visible on if_* after edge N, so if_valid is registered.
- Redirect, which has priority over every other event in the same cycle:
  - Queue is cleared, and any simultaneous pop is ignored.
  - pc_q<=redirect_pc&~3.
  - If a request is outstanding, or is accepted in the same cycle, stale<=1 and state<=WAIT. The next request is issued only after that response has been discarded.
  - If nothing is outstanding, state<=REQ, and a request to the new PC is issued on the next cycle.
  - A response arriving in the same cycle as the redirect is discarded.
  - An unaccepted request (valid=1, ready=0) is withdrawn. The memory protocol permits withdrawal only on redirect.
- Without a redirect, imem_req_valid and imem_addr stay stable until accepted.
- While if_valid=1 and if_ready=0, the if_* outputs stay stable.

Test Plan:
- Reset release, memory with ready=1 and 1-cycle response returning 0x00500093 at addr 0: imem_addr=0 on cycle 1. Then if_valid=1, if_instr=0x00500093, if_pc=0, if_pc_plus4=4. The next request has imem_addr=4.
- Hold if_ready=0 for 10 cycles: exactly two instructions are fetched (pc 0, 4), then imem_req_valid stays 0. Set if_ready=1: pc 0 then pc 4 pop in order, and fetching resumes at 8.
- redirect_valid=1, redirect_pc=0x100 while request to 0x8 is outstanding: the 0x8 response never appears on if_*. The next imem_addr is 0x100, and the first if_pc after that is 0x100.
- Redirect in the same cycle as imem_rsp_valid and a pop, with queue holding 1 entry: the queue empties and the response is dropped. The next request goes to the target with no stale wait.
- RESET_PC=32'hFFFF_FFFC: the first if_pc_plus4=0 and the second fetch address is 0. Also redirect_pc=0x103 fetches 0x100.
- rst asserted while in WAIT with 1 queued entry: on the next cycle if_valid=0, imem_req_valid=0, if_instr=0x13. Fetch then restarts at RESET_PC.
